// File: rtl/booth_divider.sv
// Sequential signed/unsigned radix-2 non-restoring divider, one quotient bit per cycle.
// Latency: start accepted on edge 0, done pulses in the cycle after edge WIDTH_DATA+2.
// Backpressure: none; start is ignored while busy, results hold until the next op completes.
module booth_divider #(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  i_signed,
  input  logic [WIDTH_DATA-1:0] dividend,
  input  logic [WIDTH_DATA-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_DATA-1:0] quotient,
  output logic [WIDTH_DATA-1:0] remainder,
  output logic                  div_zero
);

  localparam int W  = WIDTH_DATA;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t          state;
  logic [W-1:0]    dvd_l;
  logic [W-1:0]    dvs_l;
  logic            sgn_l;
  logic            sign_q;
  logic            sign_r;
  logic            dz_int;
  logic [W:0]      a_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    m_reg;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    abs_dvd;
  logic [W-1:0]    abs_dvs;
  logic [W:0]      a_shift;
  logic [W:0]      a_step;
  logic [W-1:0]    a_fix;
  logic [W-1:0]    q_res;
  logic [W-1:0]    r_res;

  // Magnitudes; the most negative value maps to its own unsigned bit pattern.
  assign abs_dvd = (sgn_l && dvd_l[W-1]) ? -dvd_l : dvd_l;
  assign abs_dvs = (sgn_l && dvs_l[W-1]) ? -dvs_l : dvs_l;

  // One non-restoring step: shift {A,Q} left, then subtract or add M by sign of A.
  assign a_shift = {a_reg[W-1:0], q_reg[W-1]};
  assign a_step  = a_reg[W] ? (a_shift + {1'b0, m_reg}) : (a_shift - {1'b0, m_reg});

  // Final remainder restore; the restored value is always in [0, M) so W bits suffice.
  assign a_fix = a_reg[W] ? (a_reg[W-1:0] + m_reg) : a_reg[W-1:0];
  assign q_res = sign_q ? -q_reg : q_reg;
  assign r_res = sign_r ? -a_fix : a_fix;

  // Control FSM and datapath registers, including the registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dvd_l     <= '0;
      dvs_l     <= '0;
      sgn_l     <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz_int    <= 1'b0;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_l <= dividend;
            dvs_l <= divisor;
            sgn_l <= i_signed;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          sign_q <= sgn_l & (dvd_l[W-1] ^ dvs_l[W-1]);
          sign_r <= sgn_l & dvd_l[W-1];
          dz_int <= (dvs_l == '0);
          a_reg  <= '0;
          q_reg  <= abs_dvd;
          m_reg  <= abs_dvs;
          cnt    <= '0;
          state  <= ITER;
        end
        ITER: begin
          a_reg <= a_step;
          q_reg <= {q_reg[W-2:0], ~a_step[W]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          a_reg <= {1'b0, a_fix};
          if (dz_int) begin
            // Divide by zero: all-ones quotient, dividend passed through untouched.
            quotient  <= '1;
            remainder <= dvd_l;
            div_zero  <= 1'b1;
          end else begin
            quotient  <= q_res;
            remainder <= r_res;
            div_zero  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed testbench for booth_divider with hand-computed expected results.
// Checks reset state, sign handling, boundaries, divide by zero, handshake and mid-op reset.
// Outputs are sampled 1ns after the rising edge; inputs are driven at the same point.
module tb_booth_divider;

  localparam int W       = 32;
  localparam int LAT     = 34;
  localparam int TIMEOUT = 100;

  logic         clk;
  logic         rst;
  logic         start;
  logic         i_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int pulses;

  booth_divider #(.WIDTH_DATA(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .i_signed  (i_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Present operands with start high, let one edge accept them, then drop start.
  task automatic launch(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    i_signed = sgn;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 'x;
    divisor  = 'x;
  endtask

  // Count edges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 1;
    while (n <= TIMEOUT) begin
      @(posedge clk);
      #1;
      if (done) break;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic edz);
    chk({tag, "_lat"}, W'(lat), W'(LAT));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, W'(div_zero), W'(edz));
    chk({tag, "_busy_at_done"}, W'(busy), W'(0));
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] dvd,
                        input logic [W-1:0] dvs, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz);
    launch(sgn, dvd, dvs);
    chk({tag, "_busy"}, W'(busy), W'(1));
    wait_done(lat);
    check_result(tag, eq, er, edz);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, W'(done), W'(0));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    i_signed = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_q", quotient, '0);
    chk("reset_r", remainder, '0);
    chk("reset_dz", W'(div_zero), W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned and signed sign combinations.
    run_op("u_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_op("s_m100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
    run_op("s_100_m7",  1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0);
    run_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0);
    run_op("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    // Same bit pattern as an unsigned divide gives a different answer.
    run_op("u_big_7",   1'b0, 32'hFFFF_FF9C,  32'd7,          32'h2492_4916,  32'd2,          1'b0);

    // Boundaries.
    run_op("u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
    run_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    run_op("u_5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0);

    // Divide by zero in both modes.
    run_op("u_dz",      1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
    run_op("s_dz",      1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1);

    // A fresh accept does not disturb held results, and div_zero clears on the next good op.
    launch(1'b0, 32'd100, 32'd7);
    chk("hold_q_on_accept", quotient, 32'hFFFF_FFFF);
    chk("hold_r_on_accept", remainder, 32'h1234_5678);
    repeat (9) @(posedge clk);
    #1;
    // Start pulsed mid-op must be ignored.
    i_signed = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat = 11;
    while (lat <= TIMEOUT) begin
      @(posedge clk);
      #1;
      if (done) break;
      lat++;
    end
    check_result("ignore_start", 32'd14, 32'd2, 1'b0);

    // Back-to-back: start presented in the done cycle is accepted.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("b2b_busy", W'(busy), W'(1));
    chk("b2b_done_low", W'(done), W'(0));
    wait_done(lat);
    check_result("b2b", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of an operation.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_q", quotient, '0);
    chk("arst_r", remainder, '0);
    chk("arst_dz", W'(div_zero), W'(0));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("arst_no_done", W'(pulses), W'(0));
    run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed/unsigned integer divider, the inverse companion to the radix-4 Booth multiplier in the arithmetic datapath.
- Computes quotient and remainder of two WIDTH_DATA-bit operands using radix-2 non-restoring division, one quotient bit per cycle.
- Uses a start/done handshake and a shift-register A:Q datapath, the same style as the multiplier, so the two blocks drop into the same ALU slot.

Parameters:
WIDTH_DATA, 32, operand/quotient/remainder width in bits (>=4)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; accepted only when busy=0
i_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
dividend  input  WIDTH_DATA  numerator; sampled with start
divisor  input  WIDTH_DATA  denominator; sampled with start
busy  output  1  high from the cycle after accepting start until done
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
quotient  output  WIDTH_DATA  result, truncated toward zero
remainder  output  WIDTH_DATA  result; sign follows dividend (signed mode)
div_zero  output  1  divisor was 0 for the last completed op; valid with done, held until next accept

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal A, Q, M and counter registers 0. rst asserted mid-operation aborts immediately; no done is produced.
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE: on clk edge with start=1, latch operands and i_signed, go to PREP, busy=1. start=0 keeps IDLE.
- PREP (1 cycle): compute magnitudes (abs when i_signed and MSB=1), record sign_q = sign(dividend) XOR sign(divisor), record sign_r = sign(dividend). Flag div_zero_int if divisor==0. Load A = 0 ({WIDTH_DATA+1} bits), Q = |dividend|, M = |divisor|, count = 0. Go to ITER.
- ITER (exactly WIDTH_DATA cycles), each cycle:
  - shift {A,Q} left 1.
  - if A >= 0 then A = A - M, else A = A + M.
  - Q[0] = ~A_new[MSB].
  - count++; leave for FIX when count == WIDTH_DATA-1 on this edge.
- FIX (1 cycle):
  - if A < 0, A = A + M (remainder restore).
  - quotient = sign_q ? -Q : Q; remainder = sign_r ? -A[WIDTH_DATA-1:0] : A[WIDTH_DATA-1:0].
  - register outputs, done=1, busy=0 next, go to IDLE.
- Latency: fixed. Start sampled at edge 0; done high in the cycle following edge WIDTH_DATA+2. Back-to-back: start may be accepted on the cycle done is high (state already IDLE).
- Divide by zero: same latency. quotient = all ones, remainder = dividend unchanged (both modes), div_zero = 1.
- Signed overflow (dividend = most negative, divisor = -1, i_signed=1): quotient = dividend, remainder = 0, div_zero = 0.
- Arithmetic widths: A is WIDTH_DATA+1 bits so that |most negative| = 2^(WIDTH_DATA-1) and the add/sub never overflow. Magnitude of the most negative value is its unsigned bit pattern.
- Hold and ignore rules:
  - start while busy=1 is ignored; operand inputs are don't-care while busy.
  - quotient/remainder/div_zero hold their values until the next FIX; they do not change on accept.
  - done is never high for two consecutive cycles.

Test Plan:
- Unsigned: i_signed=0, dividend=100, divisor=7 -> done exactly 34 cycles after start edge; quotient=14, remainder=2, div_zero=0.
- Signed signs: i_signed=1, (-100)/7 -> q=-14, r=-2. 100/(-7) -> q=-14, r=2. (-100)/(-7) -> q=14, r=-2.
- Boundaries:
  - unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
  - signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - 5/9 -> q=0, r=5.
- Divide by zero: dividend=0x12345678, divisor=0, either mode -> q=0xFFFFFFFF, r=0x12345678, div_zero=1, same latency.
- Handshake:
  - start pulsed again at cycle 10 of an op -> ignored; first result unchanged.
  - new start in the done cycle -> second op accepted; its done follows 34 cycles later.
- Reset mid-op: assert rst at cycle 15 asynchronously (between edges) -> busy, done and outputs go to 0 immediately; no done pulse. After release, a new 100/7 gives q=14, r=2.
